// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared constants, fetch state type and address-mask helper for the fetch stage.
package instr_fetch_pkg;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD  = 32'h0000_000C;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic {ST_RUN, ST_HALT} fetch_state_t;

    // Keep only word-address bits [aw-1:2]; byte offset and out-of-depth bits are cleared.
    function automatic logic [31:0] addr_mask(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] lim;
        lim = (aw >= 32) ? '1 : ((32'd1 << aw) - 32'd1);
        return addr & lim & ~32'd3;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: combinational instruction-memory bus (fetch stage is master, memory is slave).
interface instr_fetch_if;
    logic [31:0] endereco;
    logic [31:0] instrucao;
    modport master (output endereco, input instrucao);
    modport slave (input endereco, output instrucao);
endinterface

// File: rtl/instr_fetch_pc_next_sel.sv
// pc_next_sel: next-PC mux with wrap inside the memory depth, alignment clear and misaligned flag.
module pc_next_sel
    import instr_fetch_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_seq,
    output logic [31:0] pc_next,
    output logic        misaligned
);

    localparam int unsigned AW = $clog2(MEM_WORDS) + 2;

    always_comb begin
        pc_seq     = addr_mask(pc + 32'(WORD_BYTES), AW);
        pc_next    = branch_taken ? addr_mask(branch_target, AW) : pc_seq;
        misaligned = branch_taken && (branch_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and IF/ID register with stall, flush and branch redirect.
// Optional halt-on-syscall behaviour is enabled by defining INSTR_FETCH_HALT_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    instr_fetch_if.master      imem,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc4,
    output logic               if_valid,
    output logic               misaligned,
    output logic               halted
);

    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] pc_next;
    logic        mis_br;

    assign imem.endereco = pc;

    pc_next_sel #(.MEM_WORDS(MEM_WORDS)) u_sel (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_seq        (pc_seq),
        .pc_next       (pc_next),
        .misaligned    (mis_br)
    );

`ifdef INSTR_FETCH_HALT_EN
    fetch_state_t state;
    fetch_state_t state_next;
    logic         fetch_now;

    assign fetch_now = !branch_taken && !stall;

    always_ff @(posedge clk) begin
        state <= !rst_n ? ST_RUN : state_next;
    end

    // Halt is entered only by a normal capture of the syscall word.
    always_comb begin
        state_next = (state == ST_RUN && fetch_now && imem.instrucao == HALT_WORD) ? ST_HALT : state;
    end

    assign halted = (state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            if_instr   <= NOP_WORD;
            if_pc      <= 32'h0;
            if_pc4     <= 32'h0;
            if_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else if (halted) begin
            if_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else if (branch_taken) begin
            pc         <= pc_next;
            if_valid   <= 1'b0;
            misaligned <= mis_br;
        end else if (stall) begin
            if_valid   <= flush ? 1'b0 : if_valid;
            misaligned <= 1'b0;
        end else begin
            pc         <= pc_seq;
            if_instr   <= imem.instrucao;
            if_pc      <= pc;
            if_pc4     <= pc_seq;
            if_valid   <= !flush;
            misaligned <= 1'b0;
        end
    end

endmodule
